// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store path
// (port C) and the program/data loader (port L). One access is granted at a
// time. Reads are tracked until their data returns, and read data plus a
// one-cycle valid pulse are steered back to the port that issued the read.
//
// Handshake: a requester raises *_req and holds it, with a stable *_we and
// any *_addr/*_wdata, until it sees *_gnt high in the same cycle. The payload
// is taken in the grant cycle. Dropping *_req before *_gnt withdraws the
// request with no side effect. *_rvalid is a one-cycle pulse with *_rdata
// valid in that cycle. There is no back-pressure on read data.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port C always wins contention
//                           undefined -> round-robin between C and L
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  DMEM read latency in cycles, legal range 1..4
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata core request and payload
//   c_gnt, c_rvalid, c_rdata  core grant, read-valid pulse, read data
//   l_req/l_we/l_addr/l_wdata loader request and payload
//   l_gnt, l_rvalid, l_rdata  loader grant, read-valid pulse, read data
//   m_en/m_we/m_addr/m_wdata  DMEM access strobe and payload
//   m_rdata                   DMEM read data, MEM_LAT cycles after a read
//   dbg_state                 FSM state (0 = IDLE, 1 = RD_WAIT)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] lat_cnt;
    logic       owner;      // port of the outstanding read: 0 = C, 1 = L

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic       last;       // port that won the most recent grant
`endif

    logic              final_cycle;
    logic              can_grant;
    logic              any_gnt;
    logic              pick_l;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // The last cycle of a read wait doubles as an idle cycle, so a new access
    // can be granted while the previous read data is being returned.
    assign final_cycle = (state == RD_WAIT) && (lat_cnt == 3'd1);
    assign can_grant   = !rst && ((state == IDLE) || final_cycle);
    assign any_gnt     = can_grant && (c_req || l_req);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick_l = l_req && !c_req;
`else
    // On a tie the port that did not win last time goes first.
    assign pick_l = l_req && (!c_req || !last);
`endif

    assign sel_we    = pick_l ? l_we    : c_we;
    assign sel_addr  = pick_l ? l_addr  : c_addr;
    assign sel_wdata = pick_l ? l_wdata : c_wdata;

    assign c_gnt   = any_gnt && !pick_l;
    assign l_gnt   = any_gnt &&  pick_l;
    assign m_en    = any_gnt;
    assign m_we    = any_gnt && sel_we;
    assign m_addr  = any_gnt ? sel_addr  : '0;
    assign m_wdata = any_gnt ? sel_wdata : '0;

    // rst gating makes a pending read vanish the moment reset is raised.
    assign c_rvalid = !rst && final_cycle && !owner;
    assign l_rvalid = !rst && final_cycle &&  owner;
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign l_rdata  = l_rvalid ? m_rdata : '0;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            owner   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last    <= 1'b1;
`endif
        end else begin
            if (any_gnt) begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last <= pick_l;
`endif
                if (sel_we) begin
                    // Writes complete in the grant cycle.
                    state   <= IDLE;
                    lat_cnt <= 3'd0;
                end else begin
                    state   <= RD_WAIT;
                    lat_cnt <= 3'(MEM_LAT);
                    owner   <= pick_l;
                end
            end else if (state == RD_WAIT) begin
                if (lat_cnt == 3'd1) begin
                    state <= IDLE;
                end
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Four arbiter instances, one per legal MEM_LAT (instance k has MEM_LAT=k+1),
// each with its own DMEM stand-in. Only one instance is exercised at a time;
// the others sit idle. Each cycle the outputs of the active instance are
// compared with a transaction-level reference model: a list of outstanding
// reads with the cycle their data is due, a memory image and the identity of
// the previous grant winner.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int NI = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_t;

    typedef struct packed {
        logic        cg;
        logic        lg;
        logic        crv;
        logic        lrv;
        logic [31:0] crd;
        logic [31:0] lrd;
    } obs_t;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } rd_t;

    // Expected grants are {l_gnt, c_gnt}.
    typedef struct {
        port_t      c;
        port_t      l;
        logic [1:0] rr;
        logic [1:0] fp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NI-1:0]        c_req, c_we, l_req, l_we;
    logic [NI-1:0][31:0]  c_addr, c_wdata, l_addr, l_wdata;
    wire  [NI-1:0]        c_gnt, c_rvalid, l_gnt, l_rvalid, m_en, m_we, dbg_state;
    wire  [NI-1:0][31:0]  c_rdata, l_rdata, m_addr, m_wdata, m_rdata;

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc;
    rd_t         rdq[$];
    logic        prev_l;
    logic [31:0] mem_m [256];

    function automatic logic [31:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 16) return 32'hDEAD_BEEF;
        return {8'hC0, b, 8'h5A, ~b};
    endfunction

    function automatic port_t mkp(input logic r, input logic w,
                                  input logic [31:0] a, input logic [31:0] d);
        port_t p;
        p.req = r; p.we = w; p.addr = a; p.wdata = d;
        return p;
    endfunction

    function automatic port_t rnd_port();
        port_t p;
        p.req   = 1'b1;
        p.we    = 1'($urandom_range(0, 1));
        p.addr  = $urandom_range(0, 31);
        p.wdata = $urandom;
        return p;
    endfunction

    // ---------------- DUT instances and DMEM stand-ins ----------------
    for (genvar g = 0; g < NI; g++) begin : g_lat
        logic [31:0] mem  [256];
        logic [31:0] pipe [4];

        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) dut (
            .clk(clk), .rst(rst),
            .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
            .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]),
            .l_req(l_req[g]), .l_we(l_we[g]), .l_addr(l_addr[g]), .l_wdata(l_wdata[g]),
            .l_gnt(l_gnt[g]), .l_rvalid(l_rvalid[g]), .l_rdata(l_rdata[g]),
            .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
            .m_rdata(m_rdata[g]), .dbg_state(dbg_state[g])
        );

        // Read data appears g+1 cycles after the strobe; filler otherwise.
        always @(posedge clk) begin
            if (rst) begin
                for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
                for (int s = 0; s < 4; s++) pipe[s] <= 32'hBAD0_0000;
            end else begin
                if (m_en[g] && m_we[g]) mem[m_addr[g][7:0]] <= m_wdata[g];
                pipe[0] <= (m_en[g] && !m_we[g]) ? mem[m_addr[g][7:0]]
                                                 : 32'hBAD0_0000 + 32'(g);
                for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
            end
        end
        assign m_rdata[g] = pipe[g];
    end

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        rdq.delete();
        prev_l = 1'b1;
        cyc    = 0;
        for (int a = 0; a < 256; a++) mem_m[a] = init_word(a);
    endtask

    task automatic clear_inputs();
        c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
        l_req = '0; l_we = '0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // One clock cycle on instance k: drive, check against the model at the
    // falling edge, advance the model, return just after the rising edge.
    task automatic do_cycle(input int k, input port_t cp, input port_t lp,
                            output obs_t o, output logic ecg, output logic elg);
        logic        due_now, free, any, win_l, we_x;
        logic [31:0] addr_x, wd_x;
        c_req[k] = cp.req; c_we[k] = cp.we; c_addr[k] = cp.addr; c_wdata[k] = cp.wdata;
        l_req[k] = lp.req; l_we[k] = lp.we; l_addr[k] = lp.addr; l_wdata[k] = lp.wdata;
        @(negedge clk);
        o.cg  = c_gnt[k];    o.lg  = l_gnt[k];
        o.crv = c_rvalid[k]; o.lrv = l_rvalid[k];
        o.crd = c_rdata[k];  o.lrd = l_rdata[k];

        due_now = (rdq.size() > 0) && (rdq[0].due == cyc);
        free    = (rdq.size() == 0) || due_now;
        any     = free && (cp.req || lp.req);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_l = !cp.req;
`else
        win_l = (cp.req && lp.req) ? !prev_l : !cp.req;
`endif
        ecg    = any && !win_l;
        elg    = any &&  win_l;
        we_x   = win_l ? lp.we    : cp.we;
        addr_x = win_l ? lp.addr  : cp.addr;
        wd_x   = win_l ? lp.wdata : cp.wdata;

        chk1("c_gnt", o.cg, ecg);
        chk1("l_gnt", o.lg, elg);
        chk1("m_en", m_en[k], any);
        chk1("dbg_state", dbg_state[k], rdq.size() > 0);
        if (any) begin
            chk1("m_we", m_we[k], we_x);
            chk32("m_addr", m_addr[k], addr_x);
            if (we_x) chk32("m_wdata", m_wdata[k], wd_x);
        end
        chk1("c_rvalid", o.crv, due_now && (rdq[0].port == 1'b0));
        chk1("l_rvalid", o.lrv, due_now && (rdq[0].port == 1'b1));
        if (due_now) begin
            if (rdq[0].port == 1'b0) begin
                chk32("c_rdata", o.crd, rdq[0].data);
                chk32("l_rdata_idle", o.lrd, 32'h0);
            end else begin
                chk32("l_rdata", o.lrd, rdq[0].data);
                chk32("c_rdata_idle", o.crd, 32'h0);
            end
            void'(rdq.pop_front());
        end

        if (any) begin
            prev_l = win_l;
            if (we_x) mem_m[addr_x[7:0]] = wd_x;
            else rdq.push_back('{cyc + k + 1, win_l, mem_m[addr_x[7:0]]});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "simulation time limit");
    end

    // ---------------- test sequence ----------------
    initial begin
        port_t       idle, cp, lp;
        obs_t        o, o0;
        logic        ecg, elg;
        logic [1:0]  exp_g;
        vec_t        tbl [9];
        int          n, gcnt, rcnt, cg_t, lrv_t, crv_t;
        int          g_t [8];
        int          r_t [8];
        logic [31:0] r_d [8];
        logic [31:0] lrd, crd;

        idle = '0;
        cyc  = 0;

        // Reset with every request raised: nothing may leak out.
        rst    = 1'b1;
        c_req  = '1; l_req = '1; c_we = '0; l_we = '1;
        c_addr = {NI{32'h44}}; l_addr = {NI{32'h48}};
        c_wdata = {NI{32'h1111_2222}}; l_wdata = {NI{32'h3333_4444}};
        repeat (2) @(negedge clk);
        chk32("rst_gnt", 32'({c_gnt, l_gnt}), 32'h0);
        chk32("rst_m_en_we", 32'({m_en, m_we}), 32'h0);
        chk32("rst_rvalid", 32'({c_rvalid, l_rvalid}), 32'h0);
        chk32("rst_state", 32'(dbg_state), 32'h0);
        for (int k = 0; k < NI; k++) begin
            chk32("rst_m_addr", m_addr[k], 32'h0);
            chk32("rst_m_wdata", m_wdata[k], 32'h0);
            chk32("rst_c_rdata", c_rdata[k], 32'h0);
            chk32("rst_l_rdata", l_rdata[k], 32'h0);
        end
        do_reset();

        // Arbitration table, all writes, MEM_LAT=1.
        tbl[0] = '{idle, idle, 2'b00, 2'b00};
        tbl[1] = '{mkp(1'b1, 1'b1, 32'h80, 32'hA1), mkp(1'b1, 1'b1, 32'h84, 32'hB1), 2'b01, 2'b01};
        tbl[2] = '{mkp(1'b1, 1'b1, 32'h88, 32'hA2), mkp(1'b1, 1'b1, 32'h8C, 32'hB2), 2'b10, 2'b01};
        tbl[3] = '{mkp(1'b1, 1'b1, 32'h90, 32'hA3), mkp(1'b1, 1'b1, 32'h94, 32'hB3), 2'b01, 2'b01};
        tbl[4] = '{mkp(1'b1, 1'b1, 32'h98, 32'hA4), mkp(1'b1, 1'b1, 32'h9C, 32'hB4), 2'b10, 2'b01};
        tbl[5] = '{idle,                             mkp(1'b1, 1'b1, 32'hA0, 32'hB5), 2'b10, 2'b10};
        tbl[6] = '{mkp(1'b1, 1'b1, 32'hA4, 32'hA6), mkp(1'b1, 1'b1, 32'hA8, 32'hB6), 2'b01, 2'b01};
        tbl[7] = '{mkp(1'b1, 1'b1, 32'hAC, 32'hA7), idle,                             2'b01, 2'b01};
        tbl[8] = '{mkp(1'b1, 1'b1, 32'hB0, 32'hA8), mkp(1'b1, 1'b1, 32'hB4, 32'hB8), 2'b10, 2'b01};
        for (int i = 0; i < 9; i++) begin
            do_cycle(0, tbl[i].c, tbl[i].l, o, ecg, elg);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = tbl[i].fp;
`else
            exp_g = tbl[i].rr;
`endif
            chk32("tbl_gnt", 32'({o.lg, o.cg}), 32'(exp_g));
        end

        // Single read at 0x10, MEM_LAT=1.
        do_reset();
        do_cycle(0, mkp(1'b1, 1'b0, 32'h10, 32'h0), idle, o0, ecg, elg);
        do_cycle(0, idle, idle, o, ecg, elg);
        chk1("rd1_gnt", o0.cg, 1'b1);
        chk1("rd1_early_rvalid", o0.crv, 1'b0);
        chk1("rd1_rvalid", o.crv, 1'b1);
        chk32("rd1_rdata", o.crd, 32'hDEAD_BEEF);
        chk1("rd1_l_rvalid", o.lrv, 1'b0);

        // Read blocking, MEM_LAT=3: L reads, C asks one cycle later.
        do_reset();
        lp = mkp(1'b1, 1'b0, 32'h20, 32'h0);
        cp = idle;
        cg_t = -1; lrv_t = -1; crv_t = -1; lrd = '0; crd = '0;
        for (int t = 0; t < 8; t++) begin
            if (t == 1) cp = mkp(1'b1, 1'b0, 32'h24, 32'h0);
            do_cycle(2, cp, lp, o, ecg, elg);
            if (elg) lp = idle;
            if (ecg) cp = idle;
            if (o.cg && cg_t < 0) cg_t = t;
            if (o.lrv && lrv_t < 0) begin lrv_t = t; lrd = o.lrd; end
            if (o.crv && crv_t < 0) begin crv_t = t; crd = o.crd; end
        end
        chk32("blk_c_gnt_cycle", 32'(cg_t), 32'd3);
        chk32("blk_l_rvalid_cycle", 32'(lrv_t), 32'd3);
        chk32("blk_l_rdata", lrd, init_word(32'h20));
        chk32("blk_c_rvalid_cycle", 32'(crv_t), 32'd6);
        chk32("blk_c_rdata", crd, init_word(32'h24));

        // Back-to-back reads, MEM_LAT=2.
        do_reset();
        n = 0; gcnt = 0; rcnt = 0;
        for (int t = 0; t < 8; t++) begin
            cp = (n < 3) ? mkp(1'b1, 1'b0, 32'h30 + 32'(4 * n), 32'h0) : idle;
            do_cycle(1, cp, idle, o, ecg, elg);
            if (ecg) n++;
            if (o.cg && gcnt < 8) begin g_t[gcnt] = t; gcnt++; end
            if (o.crv && rcnt < 8) begin r_t[rcnt] = t; r_d[rcnt] = o.crd; rcnt++; end
        end
        chk32("b2b_grants", 32'(gcnt), 32'd3);
        chk32("b2b_rvalids", 32'(rcnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < gcnt) chk32("b2b_gnt_cycle", 32'(g_t[i]), 32'(2 * i));
            if (i < rcnt) begin
                chk32("b2b_rv_cycle", 32'(r_t[i]), 32'(2 * i + 2));
                chk32("b2b_rdata", r_d[i], init_word(32'h30 + 4 * i));
            end
        end

        // Write then read the same address from L, MEM_LAT=4.
        do_reset();
        lrv_t = -1; lrd = '0;
        for (int t = 0; t < 8; t++) begin
            if (t == 0)      lp = mkp(1'b1, 1'b1, 32'h40, 32'h1234_5678);
            else if (t == 1) lp = mkp(1'b1, 1'b0, 32'h40, 32'h0);
            else             lp = idle;
            do_cycle(3, idle, lp, o, ecg, elg);
            if (o.lrv && lrv_t < 0) begin lrv_t = t; lrd = o.lrd; end
        end
        chk32("wr_rd_rv_cycle", 32'(lrv_t), 32'd5);
        chk32("wr_rd_rdata", lrd, 32'h1234_5678);

        // Reset two cycles after a C read grant, MEM_LAT=4.
        do_reset();
        do_cycle(3, mkp(1'b1, 1'b0, 32'h10, 32'h0), idle, o, ecg, elg);
        do_cycle(3, idle, idle, o, ecg, elg);
        do_cycle(3, idle, idle, o, ecg, elg);
        rst = 1'b1;
        c_req[3] = 1'b1; c_we[3] = 1'b1; l_req[3] = 1'b1; l_we[3] = 1'b1;
        #1;
        chk1("mid_rst_c_gnt", c_gnt[3], 1'b0);
        chk1("mid_rst_l_gnt", l_gnt[3], 1'b0);
        chk1("mid_rst_m_en", m_en[3], 1'b0);
        chk1("mid_rst_state", dbg_state[3], 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("mid_rst_c_rvalid", c_rvalid[3], 1'b0);
            chk1("mid_rst_l_rvalid", l_rvalid[3], 1'b0);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int t = 0; t < 5; t++) begin
            do_cycle(3, idle, idle, o, ecg, elg);
            chk1("post_rst_c_rvalid", o.crv, 1'b0);
        end
        do_cycle(3, mkp(1'b1, 1'b1, 32'h50, 32'h55), mkp(1'b1, 1'b1, 32'h54, 32'h66), o, ecg, elg);
        chk32("post_rst_tie", 32'({o.lg, o.cg}), 32'h1);

        // Randomized traffic on every latency.
        for (int k = 0; k < NI; k++) begin
            do_reset();
            cp = idle;
            lp = idle;
            for (int t = 0; t < 300; t++) begin
                if (!cp.req) begin
                    if ($urandom_range(0, 1) == 1) cp = rnd_port();
                end else if ($urandom_range(0, 3) == 0) begin
                    cp = rnd_port();
                end else if ($urandom_range(0, 9) == 0) begin
                    cp.req = 1'b0;
                end
                if (!lp.req) begin
                    if ($urandom_range(0, 1) == 1) lp = rnd_port();
                end else if ($urandom_range(0, 3) == 0) begin
                    lp = rnd_port();
                end else if ($urandom_range(0, 9) == 0) begin
                    lp.req = 1'b0;
                end
                do_cycle(k, cp, lp, o, ecg, elg);
                if (ecg) cp.req = 1'b0;
                if (elg) lp.req = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
